// File: rtl/fsk_symbol_decoder.sv
// FSK symbol decoder: gates the frequency analyzer per symbol window, decides one bit
// from the accumulated tick counts and assembles bits LSB-first into valid/ready words.
module fsk_symbol_decoder #(
   parameter int SYMBOL_TICKS  = 50000,
   parameter int MIN_ACTIVITY  = 10000,
   parameter int MARGIN_SHIFT  = 2,
   parameter int BITS_PER_WORD = 8
) (
   input  logic                     clock,
   input  logic                     clear,
   input  logic                     enable,
   input  logic [31:0]              f1_value,
   input  logic [31:0]              f2_value,
   output logic                     analyzer_enable,
   output logic                     analyzer_clear,
   output logic [BITS_PER_WORD-1:0] data_out,
   output logic                     data_valid,
   input  logic                     data_ready,
   output logic                     bit_error,
   output logic                     overrun
);

   localparam int WW = (SYMBOL_TICKS > 1) ? $clog2(SYMBOL_TICKS) : 1;
   localparam int CW = $clog2(BITS_PER_WORD + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLR    = 3'd1,
      ACCUM  = 3'd2,
      SAMPLE = 3'd3,
      DECIDE = 3'd4
   } state_t;

   state_t                   state_r;
   state_t                   state_nx_s;
   logic [WW-1:0]            win_cnt_r;
   logic [CW-1:0]            bit_cnt_r;
   logic [BITS_PER_WORD-1:0] shift_r;
   logic [31:0]              f1s_r;
   logic [31:0]              f2s_r;

   logic [33:0]              total_s;
   logic [33:0]              f1_thr_s;
   logic [33:0]              f2_thr_s;
   logic                     is_one_s;
   logic                     is_zero_s;
   logic                     reject_s;
   logic [BITS_PER_WORD-1:0] shift_nx_s;
   logic                     word_done_s;

   // Next-state selection for the symbol-window sequencer
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (enable) state_nx_s = CLR;
            else        state_nx_s = IDLE;
         end
         CLR: begin
            if (enable) state_nx_s = ACCUM;
            else        state_nx_s = IDLE;
         end
         ACCUM: begin
            if (!enable)                                   state_nx_s = CLR;
            else if (win_cnt_r == WW'(SYMBOL_TICKS - 1))   state_nx_s = SAMPLE;
            else                                           state_nx_s = ACCUM;
         end
         SAMPLE:  state_nx_s = DECIDE;
         DECIDE:  state_nx_s = CLR;
         default: state_nx_s = IDLE;
      endcase
   end

   // Bit decision on the latched counts; the winner needs a margin over the loser
   always_comb begin
      total_s     = {2'b00, f1s_r} + {2'b00, f2s_r};
      f1_thr_s    = {2'b00, f1s_r} + ({2'b00, f1s_r} >> MARGIN_SHIFT);
      f2_thr_s    = {2'b00, f2s_r} + ({2'b00, f2s_r} >> MARGIN_SHIFT);
      is_one_s    = ({2'b00, f2s_r} > f1_thr_s);
      is_zero_s   = ({2'b00, f1s_r} > f2_thr_s);
      reject_s    = (total_s < 34'(MIN_ACTIVITY)) || !(is_one_s || is_zero_s);
      shift_nx_s  = shift_r | (BITS_PER_WORD'(is_one_s) << bit_cnt_r);
      word_done_s = (state_r == DECIDE) && !reject_s &&
                    (bit_cnt_r == CW'(BITS_PER_WORD - 1));
   end

   // State, counters, word assembly and registered outputs
   always_ff @(posedge clock) begin
      if (clear) begin
         state_r         <= IDLE;
         win_cnt_r       <= '0;
         bit_cnt_r       <= '0;
         shift_r         <= '0;
         f1s_r           <= 32'd0;
         f2s_r           <= 32'd0;
         analyzer_enable <= 1'b0;
         analyzer_clear  <= 1'b0;
         data_out        <= '0;
         data_valid      <= 1'b0;
         bit_error       <= 1'b0;
         overrun         <= 1'b0;
      end else begin
         state_r         <= state_nx_s;
         analyzer_clear  <= (state_nx_s == CLR);
         analyzer_enable <= (state_nx_s == ACCUM);
         bit_error       <= 1'b0;

         case (state_r)
            CLR: win_cnt_r <= '0;
            ACCUM: begin
               win_cnt_r <= win_cnt_r + WW'(1);
               // an aborted window discards the partial word
               if (!enable) begin
                  bit_cnt_r <= '0;
                  shift_r   <= '0;
               end
            end
            SAMPLE: begin
               f1s_r <= f1_value;
               f2s_r <= f2_value;
            end
            DECIDE: begin
               if (reject_s) begin
                  bit_error <= 1'b1;
                  bit_cnt_r <= '0;
                  shift_r   <= '0;
               end else if (word_done_s) begin
                  bit_cnt_r <= '0;
                  shift_r   <= '0;
               end else begin
                  bit_cnt_r <= bit_cnt_r + CW'(1);
                  shift_r   <= shift_nx_s;
               end
            end
            default: ;
         endcase

         // a completed word replaces the held one only if that one leaves this cycle
         if (word_done_s) begin
            if (!data_valid || data_ready) begin
               data_out   <= shift_nx_s;
               data_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fsk_symbol_decoder.sv
// Directed self-checking bench for fsk_symbol_decoder with a short symbol window;
// the analyzer is modelled by driving f1_value/f2_value per symbol.
module tb_fsk_symbol_decoder;

   logic        clock;
   logic        clear;
   logic        enable;
   logic [31:0] f1_value;
   logic [31:0] f2_value;
   logic        analyzer_enable;
   logic        analyzer_clear;
   logic [7:0]  data_out;
   logic        data_valid;
   logic        data_ready;
   logic        bit_error;
   logic        overrun;

   int vectors;
   int miscompares;

   logic       err_at_clr;
   logic       dv_at_clr;
   logic [7:0] do_at_clr;
   logic       dv_next;
   logic       err_next;
   int         cyc;
   int         aec;

   fsk_symbol_decoder #(
      .SYMBOL_TICKS  (100),
      .MIN_ACTIVITY  (20),
      .MARGIN_SHIFT  (2),
      .BITS_PER_WORD (8)
   ) dut (
      .clock           (clock),
      .clear           (clear),
      .enable          (enable),
      .f1_value        (f1_value),
      .f2_value        (f2_value),
      .analyzer_enable (analyzer_enable),
      .analyzer_clear  (analyzer_clear),
      .data_out        (data_out),
      .data_valid      (data_valid),
      .data_ready      (data_ready),
      .bit_error       (bit_error),
      .overrun         (overrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next analyzer_clear cycle, capture the outputs there and one cycle later
   task automatic wait_clr(output int n, output int ae);
      n  = 0;
      ae = 0;
      do begin
         tick();
         n++;
         if (analyzer_enable) ae++;
      end while (!analyzer_clear && n < 200);
      check("clr_seen", {31'd0, analyzer_clear}, 32'd1);
      err_at_clr = bit_error;
      dv_at_clr  = data_valid;
      do_at_clr  = data_out;
      tick();
      dv_next  = data_valid;
      err_next = bit_error;
   endtask

   task automatic sym(input logic [31:0] a, input logic [31:0] b);
      int n;
      int ae;
      f1_value = a;
      f2_value = b;
      wait_clr(n, ae);
   endtask

   task automatic send_word(input logic [7:0] w);
      logic [7:0] wv;
      wv = w;
      for (int i = 0; i < 8; i++) begin
         if (wv[i]) sym(32'd0, 32'd80);
         else       sym(32'd80, 32'd0);
         check("good_no_err", {31'd0, err_at_clr}, 32'd0);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      clear       = 1'b1;
      enable      = 1'b0;
      data_ready  = 1'b1;
      f1_value    = 32'd0;
      f2_value    = 32'd0;
      tick();
      tick();
      check("rst_ae",  {31'd0, analyzer_enable}, 32'd0);
      check("rst_ac",  {31'd0, analyzer_clear},  32'd0);
      check("rst_do",  {24'd0, data_out},        32'd0);
      check("rst_dv",  {31'd0, data_valid},      32'd0);
      check("rst_err", {31'd0, bit_error},       32'd0);
      check("rst_ovr", {31'd0, overrun},         32'd0);

      // first symbol: bit 1 of 0xA5, with window timing checks
      clear    = 1'b0;
      enable   = 1'b1;
      f1_value = 32'd0;
      f2_value = 32'd80;
      tick();
      check("clr_pulse", {31'd0, analyzer_clear}, 32'd1);
      check("clr_ae",    {31'd0, analyzer_enable}, 32'd0);
      tick();
      check("clr_1cyc",  {31'd0, analyzer_clear}, 32'd0);
      check("accum_ae",  {31'd0, analyzer_enable}, 32'd1);
      wait_clr(cyc, aec);
      check("period",    cyc + 1, 32'd103);
      check("ae_cycles", aec + 1, 32'd100);
      check("sym1_err",  {31'd0, err_at_clr}, 32'd0);
      check("sym1_dv",   {31'd0, dv_at_clr},  32'd0);

      // remaining bits of 0xA5: 0,1,0,0,1,0,1
      sym(32'd80, 32'd0);
      sym(32'd0,  32'd80);
      sym(32'd80, 32'd0);
      sym(32'd80, 32'd0);
      sym(32'd0,  32'd80);
      sym(32'd80, 32'd0);
      check("a5_dv_pre", {31'd0, dv_at_clr}, 32'd0);
      sym(32'd0,  32'd80);
      check("a5_dv",     {31'd0, dv_at_clr}, 32'd1);
      check("a5_do",     {24'd0, do_at_clr}, 32'h0000_00A5);
      check("a5_dv_hs",  {31'd0, dv_next},   32'd0);

      // three good bits, then rejects resync the word
      sym(32'd0, 32'd80);
      sym(32'd0, 32'd80);
      sym(32'd0, 32'd80);
      check("good_err0", {31'd0, err_at_clr}, 32'd0);
      sym(32'd40, 32'd45);
      check("amb_err",   {31'd0, err_at_clr}, 32'd1);
      check("err_1cyc",  {31'd0, err_next},   32'd0);
      sym(32'd10, 32'd5);
      check("low_err",   {31'd0, err_at_clr}, 32'd1);
      sym(32'd50, 32'd50);
      check("eq_err",    {31'd0, err_at_clr}, 32'd1);

      // consumer stalled: 0x3C then 0xC3 overruns
      data_ready = 1'b0;
      send_word(8'h3C);
      check("3c_dv",     {31'd0, dv_at_clr}, 32'd1);
      check("3c_do",     {24'd0, do_at_clr}, 32'h0000_003C);
      check("3c_ovr",    {31'd0, overrun},   32'd0);
      send_word(8'hC3);
      check("c3_ovr",    {31'd0, overrun},   32'd1);
      check("c3_do",     {24'd0, do_at_clr}, 32'h0000_003C);
      check("c3_dv",     {31'd0, dv_next},   32'd1);
      data_ready = 1'b1;
      tick();
      check("ovr_hs_dv", {31'd0, data_valid}, 32'd0);
      check("ovr_stays", {31'd0, overrun},    32'd1);

      // enable dropped mid-window after four good bits
      sym(32'd0, 32'd80);
      sym(32'd0, 32'd80);
      sym(32'd0, 32'd80);
      sym(32'd0, 32'd80);
      repeat (50) tick();
      enable = 1'b0;
      tick();
      check("abort_ac",  {31'd0, analyzer_clear},  32'd1);
      check("abort_ae",  {31'd0, analyzer_enable}, 32'd0);
      check("abort_err", {31'd0, bit_error},       32'd0);
      tick();
      check("idle_ac",   {31'd0, analyzer_clear},  32'd0);
      check("idle_err",  {31'd0, bit_error},       32'd0);
      tick();
      check("idle_ac2",  {31'd0, analyzer_clear},  32'd0);
      check("idle_ae",   {31'd0, analyzer_enable}, 32'd0);

      // re-enable with a stalled consumer; the word holds only new bits
      data_ready = 1'b0;
      f1_value   = 32'd80;
      f2_value   = 32'd0;
      enable     = 1'b1;
      wait_clr(cyc, aec);
      check("reen_cyc",  cyc, 32'd1);
      send_word(8'h5A);
      check("5a_dv",     {31'd0, dv_at_clr}, 32'd1);
      check("5a_do",     {24'd0, do_at_clr}, 32'h0000_005A);
      check("5a_ovr",    {31'd0, overrun},   32'd1);

      // clear in mid-window with a pending word
      repeat (30) tick();
      clear  = 1'b1;
      enable = 1'b0;
      tick();
      check("mclr_ae",  {31'd0, analyzer_enable}, 32'd0);
      check("mclr_ac",  {31'd0, analyzer_clear},  32'd0);
      check("mclr_do",  {24'd0, data_out},        32'd0);
      check("mclr_dv",  {31'd0, data_valid},      32'd0);
      check("mclr_err", {31'd0, bit_error},       32'd0);
      check("mclr_ovr", {31'd0, overrun},         32'd0);
      clear = 1'b0;
      tick();
      check("post_ac",  {31'd0, analyzer_clear},  32'd0);
      check("post_ae",  {31'd0, analyzer_enable}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
